// File: rtl/password_checker_pkg.sv
// Shared scan-code types and constants for the password checker and its benches.
package password_checker_pkg;

  localparam int SCAN_CODE_W = 8;

  typedef logic [SCAN_CODE_W-1:0] scan_code_t;

  // PS/2 break prefix sent ahead of a key-release code.
  localparam scan_code_t BREAK_CODE = 8'hF0;

  localparam scan_code_t KEY_T = 8'h2C;
  localparam scan_code_t KEY_E = 8'h24;
  localparam scan_code_t KEY_S = 8'h1B;
  localparam scan_code_t KEY_R = 8'h3C;

endpackage

// File: rtl/password_checker_thermo_encoder.sv
// Combinational progress-count to MSB-first thermometer mapping.
module thermo_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] leds
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign leds[WIDTH-1-i] = (idx > IDX_W'(i));
  end

endmodule

// File: rtl/password_checker.sv
// Sequential scan-code password matcher with thermometer progress LEDs.
// Optional: define PASSWORD_CHECKER_BREAK_FILTER_EN to drop F0 xx key-release pairs.
module password_checker
  import password_checker_pkg::*;
#(
  parameter int PASSWORD_WIDTH = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       empty,
  input  logic [SCAN_CODE_W-1:0]                     code,
  input  logic [PASSWORD_WIDTH-1:0][SCAN_CODE_W-1:0] password,
  output logic [PASSWORD_WIDTH-1:0]                  leds
);

  localparam int IDX_W = $clog2(PASSWORD_WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PASSWORD_WIDTH);

  logic [IDX_W-1:0]          idx, idx_next;
  logic                      unlocked, unlocked_next;
  logic                      compare_en;
  scan_code_t                expected;
  logic [PASSWORD_WIDTH-1:0] leds_next;

`ifdef PASSWORD_CHECKER_BREAK_FILTER_EN
  logic skip, skip_next;

  always_comb begin
    skip_next  = skip;
    compare_en = 1'b0;
    if (!empty && !unlocked) begin
      if (skip)                    skip_next  = 1'b0;
      else if (code == BREAK_CODE) skip_next  = 1'b1;
      else                         compare_en = 1'b1;
    end
  end
`else
  assign compare_en = !empty && !unlocked;
`endif

  // The character expected next is typed from the top element downwards.
  always_comb begin
    expected = '0;
    for (int i = 0; i < PASSWORD_WIDTH; i++) begin
      if (idx == IDX_W'(PASSWORD_WIDTH - 1 - i)) expected = password[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_next      = idx;
    unlocked_next = unlocked;
    if (compare_en) begin
      if (code == expected) begin
        idx_next = idx + 1'b1;
        if (idx_next == IDX_FULL) unlocked_next = 1'b1;
      end else if (code == password[PASSWORD_WIDTH-1]) begin
        idx_next = IDX_W'(1);
      end else begin
        idx_next = '0;
      end
    end
  end

  thermo_encoder #(.WIDTH(PASSWORD_WIDTH), .IDX_W(IDX_W)) u_thermo (
    .idx  (idx_next),
    .leds (leds_next)
  );

  // NOTE: sequential state uses non-blocking assignments; rst_n is active-high here.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx      <= '0;
      unlocked <= 1'b0;
      leds     <= '0;
`ifdef PASSWORD_CHECKER_BREAK_FILTER_EN
      skip     <= 1'b0;
`endif
    end else begin
      idx      <= idx_next;
      unlocked <= unlocked_next;
      leds     <= leds_next;
`ifdef PASSWORD_CHECKER_BREAK_FILTER_EN
      skip     <= skip_next;
`endif
    end
  end

endmodule

// File: tb/tb_password_checker.sv
// Self-checking bench: directed vector table plus randomized run against a progress model.
module tb_password_checker;
  import password_checker_pkg::*;

  localparam int W = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      empty;
  scan_code_t                code;
  logic [W-1:0][7:0]         password;
  logic [W-1:0]              leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  password_checker #(.PASSWORD_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty    (empty),
    .code     (code),
    .password (password),
    .leds     (leds)
  );

  typedef struct {
    logic       rst;
    logic       empty;
    scan_code_t code;
    logic [W-1:0] exp_leds;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: leds=%b expected=%b at %0t", name, actual, required, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input scan_code_t c, input logic [W-1:0] x);
    vec_t v;
    v.rst = r; v.empty = e; v.code = c; v.exp_leds = x;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic e, input scan_code_t c);
    rst_n = r; empty = e; code = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: number of correctly typed characters, from the matching rules.
  int   m_prog;
  bit   m_unlocked;
  bit   m_skip;

  function automatic logic [W-1:0] model_leds(input int prog);
    logic [W-1:0] all_ones = '1;
    return ~(all_ones >> prog);
  endfunction

  task automatic model_step(input logic r, input logic e, input scan_code_t c, input logic [W-1:0][7:0] pw);
    if (r) begin
      m_prog = 0; m_unlocked = 0; m_skip = 0;
    end else if (!e && !m_unlocked) begin
`ifdef PASSWORD_CHECKER_BREAK_FILTER_EN
      if (m_skip) begin
        m_skip = 0;
        return;
      end
      if (c == BREAK_CODE) begin
        m_skip = 1;
        return;
      end
`endif
      if (c == pw[W-1-m_prog]) begin
        m_prog++;
        if (m_prog == W) m_unlocked = 1;
      end else begin
        m_prog = (c == pw[W-1]) ? 1 : 0;
      end
    end
  endtask

  initial begin
    scan_code_t pool[5] = '{KEY_T, KEY_E, KEY_S, KEY_R, BREAK_CODE};

    rst_n = 1'b1; empty = 1'b1; code = '0;
    password = {KEY_T, KEY_E, KEY_S, KEY_T};

    // Full entry after a leading wrong key; reset carries a valid code to show precedence.
    add(1, 0, KEY_T, 4'b0000);
    add(0, 0, KEY_R, 4'b0000); add(0, 0, KEY_T, 4'b1000); add(0, 0, KEY_E, 4'b1100);
    add(0, 0, KEY_S, 4'b1110); add(0, 0, KEY_T, 4'b1111);
    // Mismatch to zero, then success.
    add(1, 0, KEY_T, 4'b0000);
    add(0, 0, KEY_T, 4'b1000); add(0, 0, KEY_E, 4'b1100); add(0, 0, KEY_R, 4'b0000);
    add(0, 0, KEY_T, 4'b1000); add(0, 0, KEY_E, 4'b1100); add(0, 0, KEY_S, 4'b1110);
    add(0, 0, KEY_T, 4'b1111);
    // Mismatching first character restarts at one.
    add(1, 0, KEY_T, 4'b0000);
    add(0, 0, KEY_T, 4'b1000); add(0, 0, KEY_E, 4'b1100); add(0, 0, KEY_T, 4'b1000);
    add(0, 0, KEY_E, 4'b1100); add(0, 0, KEY_S, 4'b1110); add(0, 0, KEY_T, 4'b1111);
    // Unlocked ignores further codes; reset clears.
    add(0, 0, KEY_R, 4'b1111); add(0, 0, KEY_R, 4'b1111); add(0, 1, KEY_R, 4'b1111);
    add(1, 0, KEY_T, 4'b0000);
    // Empty holds state.
    add(0, 1, KEY_T, 4'b0000); add(0, 0, KEY_T, 4'b1000); add(0, 1, KEY_E, 4'b1000);
    add(0, 0, KEY_E, 4'b1100);
    // Break-prefix stream.
    add(1, 0, KEY_T, 4'b0000);
`ifdef PASSWORD_CHECKER_BREAK_FILTER_EN
    add(0, 0, KEY_T, 4'b1000); add(0, 0, BREAK_CODE, 4'b1000); add(0, 0, KEY_T, 4'b1000);
    add(0, 0, KEY_E, 4'b1100); add(0, 0, BREAK_CODE, 4'b1100); add(0, 0, KEY_E, 4'b1100);
    add(0, 0, KEY_S, 4'b1110); add(0, 0, KEY_T, 4'b1111);
`else
    add(0, 0, KEY_T, 4'b1000); add(0, 0, BREAK_CODE, 4'b0000); add(0, 0, KEY_T, 4'b1000);
    add(0, 0, KEY_E, 4'b1100); add(0, 0, BREAK_CODE, 4'b0000); add(0, 0, KEY_E, 4'b0000);
    add(0, 0, KEY_S, 4'b0000); add(0, 0, KEY_T, 4'b1000);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].empty, vecs[i].code);
      check($sformatf("vec%0d", i), leds, vecs[i].exp_leds);
    end

    // Double-T start: a second T after T is a mismatch that restarts at one.
    apply(1, 0, KEY_T);
    check("seq_reset", leds, 4'b0000);
    apply(0, 0, KEY_T); apply(0, 0, KEY_T);
    check("seq_tt", leds, 4'b1000);
    // Password change mid-entry applies to the next comparison only.
    password = {KEY_T, KEY_R, KEY_S, KEY_T};
    apply(0, 0, KEY_R);
    check("seq_pw_change", leds, 4'b1100);
    password = {KEY_T, KEY_E, KEY_S, KEY_T};

    // Randomized run with a random password drawn from a small alphabet.
    for (int p = 0; p < W; p++) password[p] = pool[$urandom_range(0, 3)];
    m_prog = 0; m_unlocked = 0; m_skip = 0;
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic       e;
      scan_code_t c;
      r = (n == 0) || ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 9) == 0) ? scan_code_t'($urandom) : pool[$urandom_range(0, 4)];
      model_step(r, e, c, password);
      apply(r, e, c);
      check("random", leds, model_leds(m_prog));
      if (n % 700 == 699) begin
        for (int p = 0; p < W; p++) password[p] = pool[$urandom_range(0, 3)];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
